// File: rtl/axi_to_avst_gasket_if.sv
// Stream bundle for axi_to_avst_gasket: AXI4-Stream video ingress and Avalon-ST egress.
// The slave modport is the gasket's view; the master modport is the surrounding environment's view.
interface axi_to_avst_gasket_if;
    logic        axi_rx_tvalid;
    logic        axi_rx_tready;
    logic [63:0] axi_rx_tdata;
    logic        axi_rx_tlast;
    logic [7:0]  axi_rx_tuser;
    logic        avst_source_ready;
    logic        avst_source_valid;
    logic [95:0] avst_source_data;
    logic        avst_source_sop;
    logic        avst_source_eop;
    logic [3:0]  avst_source_empty;

    modport slave (
        input  axi_rx_tvalid, axi_rx_tdata, axi_rx_tlast, axi_rx_tuser, avst_source_ready,
        output axi_rx_tready, avst_source_valid, avst_source_data, avst_source_sop,
               avst_source_eop, avst_source_empty
    );

    modport master (
        output axi_rx_tvalid, axi_rx_tdata, axi_rx_tlast, axi_rx_tuser, avst_source_ready,
        input  axi_rx_tready, avst_source_valid, avst_source_data, avst_source_sop,
               avst_source_eop, avst_source_empty
    );
endinterface

// File: rtl/axi_to_avst_gasket.sv
// AXI4-Stream (2 px/beat, 10-bit RGB) to 96-bit Avalon-ST gasket with a 2-entry skid buffer.
// Define AXI_TO_AVST_LINE_CHECK_EN to build the line-length counter and sticky err_line_length.
module axi_to_avst_gasket #(
    parameter int BEATS_PER_LINE = 960
) (
    input  logic                   clk,
    input  logic                   resetn,
    axi_to_avst_gasket_if.slave    bus,
    input  logic                   err_clear,
    output logic                   err_line_length
);

    typedef enum logic [0:0] {WAIT_SOF = 1'b0, IN_FRAME = 1'b1} state_t;

    // Spread each 10-bit component onto its own 16-bit slot of the 96-bit word.
    function automatic logic [95:0] pack_pixels(input logic [63:0] d);
        logic [95:0] p;
        p        = 96'd0;
        p[9:0]   = d[9:0];
        p[25:16] = d[19:10];
        p[41:32] = d[29:20];
        p[57:48] = d[41:32];
        p[73:64] = d[51:42];
        p[89:80] = d[61:52];
        return p;
    endfunction

    state_t      state_r;
    logic        tready_r;
    logic        out_valid_r;
    logic [95:0] out_data_r;
    logic        out_sop_r;
    logic        out_eop_r;
    logic        skid_valid_r;
    logic [95:0] skid_data_r;
    logic        skid_sop_r;
    logic        skid_eop_r;

    logic accept_s;
    logic fwd_s;
    logic consume_s;
    logic load_from_in_s;
    logic load_from_skid_s;
    logic load_skid_s;
    logic out_valid_nxt_s;
    logic skid_valid_nxt_s;
    logic unused_s;

    assign accept_s  = bus.axi_rx_tvalid & tready_r;
    assign fwd_s     = accept_s & ((state_r == IN_FRAME) | bus.axi_rx_tuser[0]);
    assign consume_s = out_valid_r & bus.avst_source_ready;
    assign unused_s  = ^{bus.axi_rx_tuser[7:1], bus.axi_rx_tdata[63:62], bus.axi_rx_tdata[31:30]};

    // Skid steering: a held skid beat always refills the output register before new input.
    always_comb begin
        load_from_in_s   = 1'b0;
        load_from_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (skid_valid_r) begin
            if (consume_s | !out_valid_r) begin
                load_from_skid_s = 1'b1;
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s  = out_valid_r;
            end
        end else if (fwd_s) begin
            if (consume_s | !out_valid_r) begin
                load_from_in_s   = 1'b1;
                out_valid_nxt_s  = 1'b1;
            end else begin
                load_skid_s      = 1'b1;
                skid_valid_nxt_s = 1'b1;
            end
        end else if (consume_s) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Output and skid registers; tready tracks the skid occupancy it will have next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tready_r     <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 96'd0;
            out_sop_r    <= 1'b0;
            out_eop_r    <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= 96'd0;
            skid_sop_r   <= 1'b0;
            skid_eop_r   <= 1'b0;
        end else begin
            tready_r     <= !skid_valid_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            if (load_from_in_s) begin
                out_data_r <= pack_pixels(bus.axi_rx_tdata);
                out_sop_r  <= bus.axi_rx_tuser[0];
                out_eop_r  <= bus.axi_rx_tlast;
            end else if (load_from_skid_s) begin
                out_data_r <= skid_data_r;
                out_sop_r  <= skid_sop_r;
                out_eop_r  <= skid_eop_r;
            end
            if (load_skid_s) begin
                skid_data_r <= pack_pixels(bus.axi_rx_tdata);
                skid_sop_r  <= bus.axi_rx_tuser[0];
                skid_eop_r  <= bus.axi_rx_tlast;
            end
        end
    end

    // Frame-sync FSM: once the first start-of-frame is seen, only reset leaves IN_FRAME.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= WAIT_SOF;
        end else begin
            case (state_r)
                WAIT_SOF: if (fwd_s) state_r <= IN_FRAME;
                IN_FRAME: state_r <= IN_FRAME;
                default:  state_r <= WAIT_SOF;
            endcase
        end
    end

    assign bus.axi_rx_tready     = tready_r;
    assign bus.avst_source_valid = out_valid_r;
    assign bus.avst_source_data  = out_data_r;
    assign bus.avst_source_sop   = out_sop_r;
    assign bus.avst_source_eop   = out_eop_r;
    assign bus.avst_source_empty = 4'd0;

`ifdef AXI_TO_AVST_LINE_CHECK_EN
    localparam logic [16:0] BPL_C = 17'(BEATS_PER_LINE);

    logic [15:0] line_cnt_r;
    logic [15:0] line_cnt_nxt_s;
    logic [15:0] cnt_base_s;
    logic [16:0] cnt_plus_s;
    logic        line_err_s;
    logic        err_r;

    // A start-of-frame beat restarts the count at itself; a full line without tlast wraps.
    always_comb begin
        cnt_base_s     = bus.axi_rx_tuser[0] ? 16'd0 : line_cnt_r;
        cnt_plus_s     = {1'b0, cnt_base_s} + 17'd1;
        line_err_s     = 1'b0;
        line_cnt_nxt_s = line_cnt_r;
        if (fwd_s) begin
            if (bus.axi_rx_tlast) begin
                line_err_s     = (cnt_plus_s != BPL_C);
                line_cnt_nxt_s = 16'd0;
            end else if (cnt_plus_s == BPL_C) begin
                line_err_s     = 1'b1;
                line_cnt_nxt_s = 16'd0;
            end else begin
                line_cnt_nxt_s = cnt_plus_s[15:0];
            end
        end else begin
            line_cnt_nxt_s = line_cnt_r;
        end
    end

    // Line counter and sticky error; a new error beats a coincident clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            line_cnt_r <= 16'd0;
            err_r      <= 1'b0;
        end else begin
            line_cnt_r <= line_cnt_nxt_s;
            if (line_err_s) begin
                err_r <= 1'b1;
            end else if (err_clear) begin
                err_r <= 1'b0;
            end
        end
    end

    assign err_line_length = err_r;
`else
    logic unused_cfg_s;
    assign unused_cfg_s    = err_clear;
    assign err_line_length = 1'b0;
`endif

endmodule

// File: tb/tb_axi_to_avst_gasket.sv
// Randomised self-checking bench for axi_to_avst_gasket against a queue-based reference model.
module tb_axi_to_avst_gasket;
    localparam int BPL = 4;
`ifdef AXI_TO_AVST_LINE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct {
        logic [95:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic err_clear = 1'b0;
    logic err_line_length;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    int   sidx = 0;
    bit   script [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    beat_t mq [$];
    logic  m_tready = 1'b0;
    bit    m_in_frame = 1'b0;
    int    m_len = 0;
    logic  m_err = 1'b0;

    axi_to_avst_gasket_if intf ();

    axi_to_avst_gasket #(.BEATS_PER_LINE(BPL)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .bus             (intf.slave),
        .err_clear       (err_clear),
        .err_line_length (err_line_length)
    );

    always #5 clk = ~clk;

    // Pixel k of the AXI beat lives at 32*(k/3)+10*(k%3); on Avalon at 48*(k/3)+16*(k%3).
    function automatic logic [95:0] expect_pack(input logic [63:0] d);
        logic [95:0] p;
        p = 96'd0;
        for (int k = 0; k < 6; k++) begin
            p[(k / 3) * 48 + (k % 3) * 16 +: 10] = d[(k / 3) * 32 + (k % 3) * 10 +: 10];
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the gasket holds at most two forwarded beats, oldest presented first.
    always @(posedge clk or negedge resetn) begin
        bit acc;
        bit fwd;
        bit new_err;
        beat_t b;
        if (!resetn) begin
            mq.delete();
            m_tready   = 1'b0;
            m_in_frame = 1'b0;
            m_len      = 0;
            m_err      = 1'b0;
        end else begin
            acc = intf.axi_rx_tvalid && m_tready;
            fwd = acc && (m_in_frame || intf.axi_rx_tuser[0]);
            if (mq.size() > 0 && intf.avst_source_ready) void'(mq.pop_front());
            new_err = 1'b0;
            if (fwd) begin
                b.data = expect_pack(intf.axi_rx_tdata);
                b.sop  = intf.axi_rx_tuser[0];
                b.eop  = intf.axi_rx_tlast;
                mq.push_back(b);
                m_in_frame = 1'b1;
                if (intf.axi_rx_tuser[0]) m_len = 0;
                m_len++;
                if (intf.axi_rx_tlast) begin
                    if (m_len != BPL) new_err = 1'b1;
                    m_len = 0;
                end else if (m_len == BPL) begin
                    new_err = 1'b1;
                    m_len = 0;
                end
            end
            if (CHECK_EN && new_err) m_err = 1'b1;
            else if (err_clear) m_err = 1'b0;
            m_tready = (mq.size() < 2);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("tready", intf.axi_rx_tready, m_tready);
        chk("valid", intf.avst_source_valid, mq.size() > 0);
        chk("err", err_line_length, m_err);
        if (mq.size() > 0 && intf.avst_source_valid) begin
            chk("data", intf.avst_source_data, mq[0].data);
            chk("sop", intf.avst_source_sop, mq[0].sop);
            chk("eop", intf.avst_source_eop, mq[0].eop);
            chk("empty", intf.avst_source_empty, 4'd0);
        end
    end

    // Sink ready pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: intf.avst_source_ready = ($urandom_range(0, 3) != 0);
            2: begin
                intf.avst_source_ready = script[sidx % 4];
                sidx++;
            end
            3: intf.avst_source_ready = 1'b0;
            default: intf.avst_source_ready = 1'b1;
        endcase
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] d, input logic sof, input logic last);
        logic acc;
        intf.axi_rx_tvalid = 1'b1;
        intf.axi_rx_tdata  = d;
        intf.axi_rx_tuser  = {7'($urandom), sof};
        intf.axi_rx_tlast  = last;
        for (int i = 0; i < 200; i++) begin
            acc = intf.axi_rx_tready;
            @(posedge clk);
            #1;
            if (acc) begin
                intf.axi_rx_tvalid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout actual=no_accept expected=accept at %0t", $time);
        intf.axi_rx_tvalid = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic send_line(input int n, input bit with_last);
        for (int i = 0; i < n; i++) send(rnd64(), 1'b0, with_last && (i == n - 1));
    endtask

    initial begin
        intf.axi_rx_tvalid     = 1'b0;
        intf.axi_rx_tdata      = 64'd0;
        intf.axi_rx_tlast      = 1'b0;
        intf.axi_rx_tuser      = 8'd0;
        intf.avst_source_ready = 1'b1;
        #2 resetn = 1'b0;
        idle(3);
        chk("reset_tready", intf.axi_rx_tready, 1'b0);
        chk("reset_valid", intf.avst_source_valid, 1'b0);
        chk("reset_err", err_line_length, 1'b0);
        resetn = 1'b1;
        idle(1);
        chk("tready_rise", intf.axi_rx_tready, 1'b1);

        // Pre-frame garbage is dropped; the first SOF beat appears one cycle after accept.
        for (int i = 0; i < 3; i++) send(rnd64(), 1'b0, 1'b0);
        chk("pre_sof_drop", intf.avst_source_valid, 1'b0);
        send(64'h0000_0003_3FF0_0001, 1'b1, 1'b0);
        chk("sof_valid", intf.avst_source_valid, 1'b1);
        chk("sof_sop", intf.avst_source_sop, 1'b1);
        chk("sof_data", intf.avst_source_data, 96'h0000_0000_0003_03FF_0000_0001);
        send_line(3, 1'b1);

        // Two well-formed lines back to back.
        send_line(BPL, 1'b1);
        send_line(BPL, 1'b1);
        idle(2);
        chk("good_lines_err", err_line_length, 1'b0);

        // Sink ready toggling 1,0,0,1 during an 8-beat burst.
        rdy_mode = 2;
        send_line(BPL, 1'b1);
        send_line(BPL, 1'b1);
        rdy_mode = 0;
        idle(4);

        // Short line: tlast on beat 3.
        send_line(3, 1'b1);
        chk("short_line_err", err_line_length, CHECK_EN);
        idle(3);
        chk("short_line_hold", err_line_length, CHECK_EN);
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        chk("short_line_clear", err_line_length, 1'b0);

        // Five beats without tlast: error at beat 4, beat 5 starts a fresh count.
        send_line(3, 1'b0);
        chk("long_line_pre", err_line_length, 1'b0);
        send(rnd64(), 1'b0, 1'b0);
        chk("long_line_err", err_line_length, CHECK_EN);
        send(rnd64(), 1'b0, 1'b0);
        send_line(3, 1'b1);
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        chk("long_line_clear", err_line_length, 1'b0);

        // Random traffic with random backpressure, SOFs and clears.
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            err_clear = ($urandom_range(0, 7) == 0);
            send(rnd64(), ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        err_clear = 1'b0;
        rdy_mode = 0;
        idle(5);

        // Reset with the skid full.
        rdy_mode = 3;
        idle(1);
        send(rnd64(), 1'b0, 1'b0);
        send(rnd64(), 1'b0, 1'b0);
        chk("skid_full_tready", intf.axi_rx_tready, 1'b0);
        chk("skid_full_valid", intf.avst_source_valid, 1'b1);
        #1 resetn = 1'b0;
        #1;
        chk("async_reset_valid", intf.avst_source_valid, 1'b0);
        chk("async_reset_tready", intf.axi_rx_tready, 1'b0);
        idle(2);
        resetn = 1'b1;
        rdy_mode = 0;
        send(rnd64(), 1'b0, 1'b0);
        send(rnd64(), 1'b0, 1'b1);
        idle(1);
        chk("post_reset_idle", intf.avst_source_valid, 1'b0);
        send(rnd64(), 1'b1, 1'b0);
        chk("post_reset_sof", intf.avst_source_sop, 1'b1);
        send_line(3, 1'b1);
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_to_avst_gasket.md
Name: axi_to_avst_gasket

Overview:
- Ingress gasket feeding the oneAPI streaming IP from the video pipeline.
- Accepts AXI4-Stream video (2 pixels/beat, 10-bit RGB, 32-bit lanes) and re-packs it into the 96-bit Avalon-ST layout the oneAPI IP consumes.
- Fully registered via a 2-entry skid buffer; drops pre-frame garbage until start-of-frame; optionally checks line length.

Parameters:
- BEATS_PER_LINE, 960, expected beats between tlast markers (1920 px / 2); counter width 16 bits, legal range 1..65535.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- axi_rx_tvalid  in  1  AXI4-S valid
- axi_rx_tready  out  1  AXI4-S ready
- axi_rx_tdata  in  64  {2'b0, p1_r, p1_g, p1_b, 2'b0, p0_r, p0_g, p0_b}, 10 bits each
- axi_rx_tlast  in  1  end of line
- axi_rx_tuser  in  8  bit0 = start of frame; bits 7:1 ignored
- avst_source_ready  in  1  Avalon-ST ready (readyLatency 0)
- avst_source_valid  out  1  Avalon-ST valid
- avst_source_data  out  96  packed pixels
- avst_source_sop  out  1  start of frame
- avst_source_eop  out  1  end of line
- avst_source_empty  out  4  always 0
- err_clear  in  1  clears err_line_length
- err_line_length  out  1  sticky line-length error

Behaviour:
- Reset: axi_rx_tready=0, avst_source_valid=0, data/sop/eop/empty=0, err_line_length=0, skid empty, line count=0, FSM=WAIT_SOF. axi_rx_tready rises the first clk after resetn deasserts.
- Packing:
  - p0_b->data[9:0], p0_g->[25:16], p0_r->[41:32].
  - p1_b->[57:48], p1_g->[73:64], p1_r->[89:80].
  - All other data bits 0; sop=tuser[0]; eop=tlast.
- Handshake: AXI beat accepted when tvalid&tready. Avalon beat consumed when valid&ready. avst_source_valid must not depend combinationally on avst_source_ready.
- Skid buffer: output register plus one skid register.
  - axi_rx_tready is a register equal to !skid_full.
  - Latency: accepted beat appears on avst_source_* 1 cycle later.
  - Throughput: 1 beat/clk while ready is held high.
  - A ready drop spills at most one beat into the skid; the skid drains first once ready returns.
  - Simultaneous accept and consume with skid empty: the output register reloads directly, tready stays 1.
- FSM:
  - WAIT_SOF: accepted beats with tuser[0]=0 are discarded (never forwarded, never counted). A beat with tuser[0]=1 is forwarded; go to IN_FRAME.
  - IN_FRAME: all accepted beats are forwarded. tuser[0]=1 mid-line is forwarded with sop=1, the line count restarts at this beat, and no error is raised. No return to WAIT_SOF except by reset.
- Line counter (see optional feature):
  - Counts forwarded beats; resets to 0 after a tlast beat.
  - Error if the tlast beat's count+1 != BEATS_PER_LINE, or if count reaches BEATS_PER_LINE with tlast=0 (count then wraps to 0).
  - Errors set err_line_length one clk after the offending beat is accepted. The error is sticky until err_clear; if err_clear and a new error coincide, the error wins.
  - Beats are still forwarded unchanged on error.
- Reset mid-operation: beats in the skid/output registers are lost; valid drops immediately (async); FSM returns to WAIT_SOF.

Optional Feature:
- AXI_TO_AVST_LINE_CHECK_EN defined: line counter and err_line_length logic present as above.
- Not defined: no counter; err_line_length tied 0; err_clear unused; datapath and handshake identical.

Test Plan:
- Reset, then 3 beats with tuser=0 followed by a beat with tuser=1, tdata=64'h0000_0003_3FF0_0001 -> first 3 dropped; output sop=1, data[9:0]=10'h001, data[41:32]=10'h3FF, 1 clk after accept.
- BEATS_PER_LINE=4, ready held 1, 2 lines of 4 beats, tlast on beats 4 and 8 -> 8 outputs back-to-back, eop on 4th and 8th, err_line_length=0, tready never drops.
- avst_source_ready toggles 1,0,0,1 during an 8-beat burst -> tready falls one clk after the skid fills; output order and data are unchanged; no beat is lost or duplicated.
- With the check enabled, a line with tlast on beat 3 (BEATS_PER_LINE=4) -> err_line_length=1 next clk, holds, and clears after a 1-clk err_clear pulse.
- 5 beats without tlast -> error at the 4th beat; the 5th beat is forwarded normally.
- resetn pulsed low mid-line with the skid full -> valid=0 immediately; after release, output stays idle until the next tuser[0]=1 beat.
